// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller that times bits, windows the sampler, and checks parity and stop.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  data_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [PRESCALE_W-1:0] MIN_P = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_q, edge_d, p_q, p_d, half, half_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d, data_q, data_d;
    logic                    par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                    valid_q, valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                    samp_en_q, samp_en_d, wrap, capture;

    // Next-state: bit timing, frame sequencing, data assembly and error evaluation.
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        p_d       = p_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        half      = p_q >> 1;
        wrap      = edge_q == p_q - ONE;
        capture   = edge_q == half + TWO;
        if (state_q == IDLE) begin
            if (!RX_in) begin
                state_d   = START;
                edge_d    = '0;
                bit_d     = '0;
                p_d       = prescale < MIN_P ? MIN_P : prescale;
                par_en_d  = PAR_EN;
                par_typ_d = PAR_TYP;
                par_err_d = 1'b0;
                stp_err_d = 1'b0;
            end
        end else begin
            edge_d = wrap ? '0 : edge_q + ONE;
            case (state_q)
                START: begin
                    if (capture && sampled_bit) begin
                        state_d = IDLE;
                        edge_d  = '0;
                    end else if (wrap) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (capture) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (wrap) begin
                        bit_d = bit_q + BW'(1);
                        if (bit_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (capture) par_err_d = sampled_bit != (^shift_q ^ par_typ_q);
                    if (wrap) state_d = STOP;
                end
                STOP: begin
                    if (capture) begin
                        state_d   = IDLE;
                        edge_d    = '0;
                        stp_err_d = ~sampled_bit;
                        if (sampled_bit && !par_err_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        half_d    = p_d >> 1;
        samp_en_d = state_d != IDLE && edge_d >= half_d - ONE && edge_d <= half_d + ONE;
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            p_q       <= MIN_P;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            samp_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            p_q       <= p_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            samp_en_q <= samp_en_d;
        end
    end

    assign data_samp_en = samp_en_q;
    assign P_DATA       = data_q;
    assign data_valid   = valid_q;
    assign par_err      = par_err_q;
    assign stp_err      = stp_err_q;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: randomized frame driver with a scoreboard monitor for the UART receive controller.
module tb_uart_rx_fsm;
    logic       clk = 0, rst = 1, RX_in = 1, PAR_EN = 0, PAR_TYP = 0, sampled_bit;
    logic [5:0] prescale = 6'd8;
    logic       data_samp_en, data_valid, par_err, stp_err;
    logic [7:0] P_DATA;
    logic [2:0] smp;

    int checks = 0, errors = 0, cyc = 0, n_valid = 0, valid_cyc = 0, frame_start = 0;
    logic [7:0] exp_q[$];
    int         en_cycs[$];
    bit         rec_en = 0, exp_par = 0, exp_stp = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_fsm dut (
        .clk(clk), .rst(rst), .RX_in(RX_in), .prescale(prescale), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .data_samp_en(data_samp_en),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Majority-of-three sampler standing in for the real data sampler.
    always @(posedge clk or posedge rst)
        if (rst) smp <= 3'b111;
        else if (data_samp_en) smp <= {smp[1:0], RX_in};
    assign sampled_bit = (smp[0] & smp[1]) | (smp[1] & smp[2]) | (smp[0] & smp[2]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding good frame.
    always @(negedge clk) begin
        if (rec_en && data_samp_en) en_cycs.push_back(cyc);
        if (data_valid) begin
            valid_cyc = cyc;
            n_valid++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual P_DATA=%0h expected no valid", P_DATA);
            end else chk("p_data", {24'd0, P_DATA}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_samp_en"}, {31'd0, data_samp_en}, 0);
        chk({tag, "_p_data"}, {24'd0, P_DATA}, 0);
        chk({tag, "_valid"}, {31'd0, data_valid}, 0);
        chk({tag, "_par_err"}, {31'd0, par_err}, 0);
        chk({tag, "_stp_err"}, {31'd0, stp_err}, 0);
    endtask

    // Drives one frame; abort >= 0 asserts rst midway through that bit index instead of finishing.
    task automatic send_frame(input logic [7:0] d, input int pre, input bit pe, input bit pt,
                              input bit flip, input bit stopb, input int abort);
        int p = pre < 8 ? 8 : pre;
        bit pb = (pt ? ~^d : ^d) ^ flip;
        bit fb[11];
        int n = 9;
        fb[0] = 0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
        if (pe) fb[n++] = pb;
        fb[n++] = stopb;
        if (abort < 0) begin
            exp_par = pe && flip;
            exp_stp = !stopb;
            if (!exp_par && !exp_stp) begin
                exp_q.push_back(d);
                last_good = d;
            end
        end
        prescale = 6'(pre);
        PAR_EN = pe;
        PAR_TYP = pt;
        frame_start = cyc;
        for (int i = 0; i < n; i++) begin
            RX_in = fb[i];
            for (int c = 0; c < p; c++) begin
                if (i == abort && c == p / 2) begin
                    #2 rst = 1;
                    #1 chk_reset_outputs("midframe_rst");
                    @(posedge clk);
                    #1 rst = 0;
                    RX_in = 1;
                    exp_par = 0;
                    exp_stp = 0;
                    last_good = 8'h00;
                    return;
                end
                step(1);
                if (i == 0 && c == 0) begin
                    prescale = 6'($urandom);
                    PAR_EN = 1'($urandom);
                    PAR_TYP = 1'($urandom);
                end
            end
            if (i == 0) chk("flags_clear_at_start", {30'd0, par_err, stp_err}, 0);
        end
        RX_in = 1;
    endtask

    task automatic check_idle(input string tag);
        step(4);
        chk({tag, "_sb_drained"}, exp_q.size(), 0);
        chk({tag, "_par_err"}, {31'd0, par_err}, {31'd0, exp_par});
        chk({tag, "_stp_err"}, {31'd0, stp_err}, {31'd0, exp_stp});
        chk({tag, "_p_data_hold"}, {24'd0, P_DATA}, {24'd0, last_good});
        chk({tag, "_samp_en_idle"}, {31'd0, data_samp_en}, 0);
    endtask

    initial begin
        int pres[8] = '{3, 8, 12, 13, 16, 20, 32, 40};
        int nv;
        step(3);
        chk_reset_outputs("reset");
        rst = 0;
        step(5);

        rec_en = 1;
        send_frame(8'hA5, 8, 0, 0, 0, 1, -1);
        step(3);
        rec_en = 0;
        chk("t1_valid_latency", valid_cyc - frame_start, 80);
        chk("t1_samp_en_count", en_cycs.size(), 30);
        for (int b = 0; b < 10; b++)
            for (int o = 3; o <= 5; o++)
                if (en_cycs.size() > 0) chk("t1_samp_en_cycle", en_cycs.pop_front(), frame_start + 1 + 8 * b + o);
        check_idle("t1");

        send_frame(8'h3C, 16, 1, 0, 0, 1, -1);
        check_idle("t2_good");
        send_frame(8'h3C, 16, 1, 0, 1, 1, -1);
        check_idle("t2_bad_par");

        send_frame(8'h96, 8, 0, 0, 0, 0, -1);
        check_idle("t3_bad_stop");
        send_frame(8'h69, 8, 0, 0, 0, 1, -1);
        check_idle("t3_recover");

        nv = n_valid;
        prescale = 6'd8;
        RX_in = 0;
        step(2);
        RX_in = 1;
        step(20);
        exp_par = 0;
        exp_stp = 0;
        chk("t4_no_valid", n_valid, nv);
        check_idle("t4_glitch");

        nv = n_valid;
        send_frame(8'h00, 32, 0, 0, 0, 1, -1);
        send_frame(8'hFF, 32, 0, 0, 0, 1, -1);
        check_idle("t5_b2b");
        chk("t5_two_valids", n_valid - nv, 2);

        send_frame(8'h77, 8, 0, 0, 0, 1, 5);
        step(16);
        check_idle("t6_after_rst");
        send_frame(8'h5A, 8, 1, 1, 0, 1, -1);
        check_idle("t6_recover");

        for (int k = 0; k < 30; k++) begin
            int p = pres[$urandom_range(0, 7)];
            bit bad_stop = (p <= 8) && ($urandom_range(0, 3) == 0);
            send_frame(8'($urandom), p, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, !bad_stop, -1);
            if ($urandom_range(0, 1) == 1) check_idle("rand");
        end
        check_idle("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
